// File: rtl/protocol_pkg.sv
// -----------------------------------------------------------------------------
// protocol_pkg
// Purpose : MCU <-> FPGA frame layout shared by the SPI link and the synth
//           core. synth_t is the packed register image carried over SPI; the
//           first byte on the wire is the most significant byte of the struct.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package protocol_pkg;

  localparam int NUM_WAVE_GENS = 4;

  // Byte-wide so the whole struct stays a multiple of 8 bits.
  typedef enum logic [7:0] {
    SAWTOOTH = 8'd0,
    SIN      = 8'd1,
    SQUARE   = 8'd2,
    PIANO    = 8'd3
  } wave_shape_t;

  typedef struct packed {
    logic [31:0] gain;
    logic [31:0] duration;
  } envelope_t;

  typedef struct packed {
    logic [31:0] freq;
    wave_shape_t shape;
    envelope_t   envelope;
  } wave_gen_t;

  typedef struct packed {
    logic [31:0]                       reverb;
    logic [31:0]                       volume;
    wave_gen_t [NUM_WAVE_GENS-1:0]     wave_gens;
  } synth_t;

endpackage

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Purpose : constants and types for the SPI slave that loads synth_t frames.
//           SYNTH_FRAME_BYTES : bytes in one synth_t frame.
//           SPI_ECHO_PREAMBLE : byte echoed on MISO while byte 0 is received.
//           spi_state_t       : receive FSM states.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SYNTH_FRAME_BYTES = $bits(protocol_pkg::synth_t) / 8;

  localparam logic [7:0] SPI_ECHO_PREAMBLE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CHECK  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Purpose : multi-flop synchroniser for one asynchronous pin, followed by a
//           rise/fall detector on the synchronised level. All instances share
//           the same depth, so signals sampled together keep equal delay.
// Ports   :
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (chain clears to 0)
//   i_async  in   asynchronous pin
//   o_level  out  synchronised level
//   o_rise   out  one-clk pulse on a synchronised 0->1 transition
//   o_fall   out  one-clk pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/synth_spi_slave.sv
// -----------------------------------------------------------------------------
// synth_spi_slave
// Purpose : SPI mode-0 slave that receives one complete synth_t frame from the
//           MCU, assembles it in a shadow buffer and commits it atomically to
//           synth_out. Bits are LSB first; byte 0 lands in the MSB byte.
//           Incomplete, partial-byte or overlong frames are discarded with a
//           frame_err pulse and synth_out keeps its previous value.
// Config  : define SPI_ECHO_EN to echo the previously received byte on MISO
//           (8'hA5 during byte 0). Without it MISO is tied low.
// Ports   :
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sclk         in   SPI clock (async)
//   csel         in   SPI chip select, active low (async)
//   mosi         in   SPI data in (async)
//   miso         out  SPI data out
//   synth_out    out  last committed frame
//   frame_valid  out  one-clk pulse when synth_out is updated
//   frame_err    out  one-clk pulse when a frame is discarded
//   busy         out  high while a frame is in progress
//   o_dbg_state  out  receive FSM state (spi_state_t encoding)
//
// Handshake: there is no backpressure. frame_valid and frame_err are single
// cycle strobes; synth_out is stable from the frame_valid cycle until the next
// frame_valid (or reset), so a consumer may latch it at any time in between.
// -----------------------------------------------------------------------------
module synth_spi_slave
  import spi_pkg::*;
#(
  parameter int FRAME_BYTES = SYNTH_FRAME_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     csel,
  input  logic                     mosi,
  output logic                     miso,
  output logic [FRAME_BYTES*8-1:0] synth_out,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy,
  output logic [1:0]               o_dbg_state
);

  localparam int CNT_W = $clog2(FRAME_BYTES + 1);

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic w_sclk_level;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_csel_level;
  logic w_csel_rise;
  logic w_csel_fall;
  logic w_mosi;
  logic w_mosi_rise;
  logic w_mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sclk),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_csel (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (csel),
    .o_level (w_csel_level),
    .o_rise  (w_csel_rise),
    .o_fall  (w_csel_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  // Edge/level outputs that this block does not need.
  logic [3:0] w_unused_sync;
  assign w_unused_sync = {w_sclk_level, w_csel_level, w_mosi_rise, w_mosi_fall};

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  spi_state_t r_state;
  spi_state_t w_next_state;

  logic [2:0]             r_bit_cnt;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic                   r_overrun;
  logic [6:0]             r_shift;
  logic [FRAME_BYTES*8-1:0] r_shadow;
  logic [FRAME_BYTES*8-1:0] r_synth_out;
  logic                   r_frame_valid;
  logic                   r_frame_err;

  logic w_busy;
  logic w_commit;
  logic w_discard;
  logic w_frame_ok;
  logic w_start;
  logic w_sample;
  logic w_frame_full;
  logic w_byte_done;
  logic [7:0] w_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_csel_fall) w_next_state = ACTIVE;
      ACTIVE:  if (w_csel_rise) w_next_state = CHECK;
      CHECK:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_frame_full = (r_byte_cnt == CNT_W'(FRAME_BYTES));
  assign w_frame_ok   = w_frame_full && (r_bit_cnt == 3'd0) && !r_overrun;

  always_comb begin
    w_busy    = 1'b0;
    w_commit  = 1'b0;
    w_discard = 1'b0;
    case (r_state)
      ACTIVE: w_busy = 1'b1;
      CHECK: begin
        w_busy    = 1'b1;
        w_commit  = w_frame_ok;
        w_discard = !w_frame_ok;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Deserialiser
  // ---------------------------------------------------------------------------
  assign w_start = (r_state == IDLE) && w_csel_fall;

  // A csel rise in the same cycle as an sclk rise ends the frame; that bit is
  // dropped and the frame is judged on the counts already accumulated.
  assign w_sample    = (r_state == ACTIVE) && w_sclk_rise && !w_csel_rise;
  assign w_byte_done = w_sample && !w_frame_full && (r_bit_cnt == 3'd7);

  // Right-shifting register: after seven bits the first one sits in bit 0, so
  // the eighth (live) bit completes the LSB-first byte on top.
  assign w_byte = {w_mosi, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_overrun  <= 1'b0;
      r_shift    <= '0;
    end else if (w_start) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_overrun  <= 1'b0;
    end else if (w_sample) begin
      if (w_frame_full) begin
        r_overrun <= 1'b1;
      end else begin
        r_shift   <= {w_mosi, r_shift[6:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_byte_done) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        if (r_byte_cnt == CNT_W'(i)) begin
          r_shadow[FRAME_BYTES*8-1-8*i -: 8] <= w_byte;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit / discard
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_synth_out   <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      r_frame_err   <= w_discard;
      if (w_commit) begin
        r_synth_out <= r_shadow;
      end
    end
  end

  assign synth_out   = r_synth_out;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign busy        = w_busy;
  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // MISO echo
  // ---------------------------------------------------------------------------
`ifdef SPI_ECHO_EN
  logic [7:0] r_echo;
  logic       r_miso;

  // Bit 0 of the preamble is presented as soon as the frame opens, since in
  // mode 0 the first sclk rise comes before any falling edge. Each later bit
  // is the echo byte indexed by the bit counter after the preceding rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo <= '0;
      r_miso <= 1'b0;
    end else if (w_start) begin
      r_echo <= SPI_ECHO_PREAMBLE;
      r_miso <= SPI_ECHO_PREAMBLE[0];
    end else if (r_state != ACTIVE) begin
      r_miso <= 1'b0;
    end else begin
      if (w_byte_done) begin
        r_echo <= w_byte;
      end
      if (w_sclk_fall) begin
        r_miso <= r_echo[r_bit_cnt];
      end
    end
  end

  assign miso = r_miso;
`else
  logic w_unused_sclk_fall;
  assign w_unused_sclk_fall = w_sclk_fall;
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_synth_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_synth_spi_slave
// Drives MCU-side SPI mode-0 frames into synth_spi_slave. The driver pushes the
// expected outcome of each frame ({is_err, synth_out}) when it raises csel; a
// monitor pops and compares on every frame_valid/frame_err pulse, including
// the csel-to-pulse latency. MISO is collected per byte and compared with the
// echo the MCU should see (or 0 when the echo feature is not built).
// -----------------------------------------------------------------------------
module tb_synth_spi_slave;
  import protocol_pkg::*;
  import spi_pkg::*;

  localparam int FB  = SYNTH_FRAME_BYTES;
  localparam int FW  = FB * 8;
  localparam int LAT = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk  = 1'b0;
  logic          csel  = 1'b1;
  logic          mosi  = 1'b0;
  logic          miso;
  logic [FW-1:0] synth_out;
  logic          frame_valid;
  logic          frame_err;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  synth_spi_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .csel        (csel),
    .mosi        (mosi),
    .miso        (miso),
    .synth_out   (synth_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [FW:0]   exp_q[$];          // {is_err, expected synth_out}
  logic [7:0]    tx_bytes [0:FB];   // bytes of the frame being sent (+1 spare)
  logic [FW-1:0] model_out = '0;    // last frame the slave should hold
  int            rise_cyc = 0;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string name, input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack_bytes();
    logic [FW-1:0] m;
    m = '0;
    for (int i = 0; i < FB; i++) m = {m[FW-9:0], tx_bytes[i]};
    return m;
  endfunction

  task automatic load_struct(input synth_t s);
    logic [FW-1:0] v;
    v = s;
    for (int i = 0; i < FB; i++) tx_bytes[i] = v[FW-1-8*i -: 8];
  endtask

  task automatic randomize_bytes();
    for (int i = 0; i <= FB; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic monitor();
    logic [FW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && (frame_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", FW'({frame_err, frame_valid}), '0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", FW'({frame_err, frame_valid}),
              e[FW] ? FW'(2'b10) : FW'(2'b01));
          chk("synth_out", synth_out, e[FW-1:0]);
          chk("latency", FW'(cyc - rise_cyc), FW'(LAT));
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // MCU driver
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int idx, input int half);
    logic [7:0] b;
    logic [7:0] got;
    logic [7:0] exp;
    b = tx_bytes[idx];
    got = '0;
    for (int k = 0; k < 8; k++) begin
      mosi = b[k];
      wait_clk(half);
      sclk = 1'b1;
      got[k] = miso;
      wait_clk(half);
      sclk = 1'b0;
    end
`ifdef SPI_ECHO_EN
    if (idx == 0) exp = SPI_ECHO_PREAMBLE;
    else          exp = tx_bytes[idx-1];
`else
    exp = 8'h00;
`endif
    chk("miso_echo", FW'(got), FW'(exp));
  endtask

  task automatic send_frame(input int nbytes, input int extra, input int half,
                            input bit coincident, input bit close);
    bit ok;
    csel = 1'b0;
    wait_clk(2 * half);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(i, half);
      if (i == 0) chk("busy_active", FW'(busy), FW'(1'b1));
    end
    for (int k = 0; k < extra; k++) begin
      mosi = tx_bytes[nbytes][k];
      wait_clk(half);
      sclk = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
    if (close) begin
      wait_clk(half);
      ok = (nbytes == FB) && (extra == 0);
      if (ok) model_out = pack_bytes();
      exp_q.push_back({!ok, model_out});
      if (coincident) sclk = 1'b1;
      csel = 1'b1;
      rise_cyc = cyc;
      wait_clk(half);
      sclk = 1'b0;
      wait_clk(20);
      chk("busy_idle", FW'(busy), '0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  synth_t s_ref;

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    wait_clk(3);
    chk("rst_synth_out", synth_out, '0);
    chk("rst_valid", FW'(frame_valid), '0);
    chk("rst_err", FW'(frame_err), '0);
    chk("rst_busy", FW'(busy), '0);
    chk("rst_miso", FW'(miso), '0);
    rst_n = 1'b1;
    wait_clk(5);

    // Full frame, 48-clk sclk period
    s_ref = '0;
    s_ref.reverb = 32'hfeedbac4;
    s_ref.volume = 32'hdeadbeef;
    s_ref.wave_gens[0].freq = 32'h01234567;
    s_ref.wave_gens[1].freq = 32'h89abcdef;
    s_ref.wave_gens[2].freq = 32'hbebafa11;
    s_ref.wave_gens[3].freq = 32'habba1337;
    s_ref.wave_gens[0].shape = SAWTOOTH;
    s_ref.wave_gens[1].shape = SIN;
    s_ref.wave_gens[2].shape = SQUARE;
    s_ref.wave_gens[3].shape = PIANO;
    for (int g = 0; g < NUM_WAVE_GENS; g++) begin
      s_ref.wave_gens[g].envelope.gain     = 32'h12349001;
      s_ref.wave_gens[g].envelope.duration = 32'h42005678;
    end
    load_struct(s_ref);
    send_frame(FB, 0, 24, 1'b0, 1'b1);
    chk("struct_exact", synth_out, s_ref);

    // Short frame
    randomize_bytes();
    send_frame(FB - 1, 0, 8, 1'b0, 1'b1);
    chk("short_keeps", synth_out, s_ref);

    // Full frame plus 3 extra bits
    randomize_bytes();
    send_frame(FB, 3, 8, 1'b0, 1'b1);

    // Overlong frame
    randomize_bytes();
    send_frame(FB + 1, 0, 8, 1'b0, 1'b1);
    chk("overlong_keeps", synth_out, s_ref);

    // csel low with no sclk edges
    send_frame(0, 0, 8, 1'b0, 1'b1);

    // Random full frame closed by a simultaneous sclk/csel rise
    randomize_bytes();
    send_frame(FB, 0, 8, 1'b1, 1'b1);

    // Reset after 10 bytes
    randomize_bytes();
    send_frame(10, 0, 8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_out = '0;
    chk("midrst_synth_out", synth_out, '0);
    chk("midrst_busy", FW'(busy), '0);
    chk("midrst_pulses", FW'({frame_err, frame_valid}), '0);
    wait_clk(3);
    csel = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);

    // All-0x42 frame after reset
    for (int i = 0; i <= FB; i++) tx_bytes[i] = 8'h42;
    send_frame(FB, 0, 8, 1'b0, 1'b1);

    // Bit and byte order
    for (int i = 0; i <= FB; i++) tx_bytes[i] = 8'h00;
    tx_bytes[0] = 8'h01;
    send_frame(FB, 0, 8, 1'b0, 1'b1);
    chk("msb_byte", FW'(synth_out[FW-1 -: 8]), FW'(8'h01));

    wait_clk(20);
    chk("queue_drained", FW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_spi_slave.md
Name: synth_spi_slave

Overview:
- FPGA-side SPI slave that receives one full `synth_t` frame from the MCU.
- Deserialises the frame in the system clock domain and commits it atomically to the synth core.
- Sits between the top-level `ck_*` pins and the oscillator/reverb/volume register set.
- Optionally echoes each received byte on MISO so the MCU can verify the link.

Parameters:
- FRAME_BYTES, `$bits(synth_t)/8`, number of bytes in one complete frame.
- SYNC_STAGES, 2, synchroniser depth for sclk, csel and mosi.

Ports:
- clk  in  1  system clock (100 MHz), all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from MCU; asynchronous; at least 8 clk periods per half-cycle.
- csel  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out.
- synth_out  out  FRAME_BYTES*8  last committed frame, cast to `synth_t` by the consumer.
- frame_valid  out  1  one-clk pulse when synth_out is updated.
- frame_err  out  1  one-clk pulse when a frame is discarded.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: synth_out = 0, frame_valid = 0, frame_err = 0, busy = 0, miso = 0, FSM = IDLE, counters = 0, shadow buffer = 0.
- SPI mode 0:
  - MCU drives mosi on sclk falling edge; slave samples on sclk rising edge.
  - Sampling uses synchronised sclk and synchronised mosi of equal delay.
- Bit order within a byte: LSB first. The k-th sampled bit of a byte goes to bit k.
- Byte order: byte i of the frame maps to synth_out[FRAME_BYTES*8-1-8*i -: 8], i.e. first byte = MSB byte of the packed struct.
- Bytes are assembled into a shadow buffer. synth_out changes only on commit, never mid-frame.
- FSM states:
  - IDLE: csel_sync high. On csel_sync falling edge: clear bit_cnt and byte_cnt, go to ACTIVE, busy = 1.
  - ACTIVE: on each sclk rising edge shift in one bit and increment bit_cnt (3 bits, wraps 7→0). When bit_cnt wraps, write the byte to shadow[byte_cnt] and increment byte_cnt, saturating at FRAME_BYTES.
    - Sample bits arriving when byte_cnt == FRAME_BYTES: set the overrun flag, do not write.
    - On csel_sync rising edge: go to CHECK.
  - CHECK (1 clk):
    - If byte_cnt == FRAME_BYTES, bit_cnt == 0 and no overrun: synth_out ← shadow, frame_valid = 1.
    - Otherwise: frame_err = 1 and synth_out is unchanged.
    - Next state IDLE, busy = 0.
- Latency: the frame_valid pulse occurs SYNC_STAGES+2 clk after the csel rising edge reaches the pin, i.e. 4 clk at defaults.
- Simultaneous sclk rise and csel rise in the same synchronised cycle: csel wins; the bit is discarded and the frame is then judged on its counts.
- csel low with no sclk edges, then high: byte_cnt = 0, so frame_err.
- Reset asserted mid-frame: everything returns to reset values immediately, including synth_out = 0, and no pulses are emitted. The first frame after reset release needs a fresh csel falling edge.
- sclk edges while in IDLE are ignored.

Optional Feature:
- Macro: SPI_ECHO_EN.
- With SPI_ECHO_EN defined:
  - miso carries the previously received byte, LSB first. The output bit is updated on the synchronised sclk falling edge.
  - During byte 0 it carries 8'hA5.
  - miso = 0 while in IDLE.
- Without SPI_ECHO_EN: miso is held at 0 and no echo register is synthesised.

Decomposition:
- Shared package spi_pkg:
  - localparam SYNTH_FRAME_BYTES = `$bits(synth_t)/8`.
  - Typedef spi_state_t {IDLE, ACTIVE, CHECK}.
  - localparam SPI_ECHO_PREAMBLE = 8'hA5.
  - synth_t itself stays in protocol_pkg.
- Sub-module spi_sync: SYNC_STAGES-flop synchroniser plus rise/fall edge detect, instantiated for sclk, csel and mosi (mosi uses the level output only).

Test Plan:
- Full frame, MCU-side sclk period 48 clk:
  - Stimulus: reverb = 32'hfeedbac4, volume = 32'hdeadbeef, wave_gens[0..3].freq = 01234567 / 89abcdef / bebafa11 / abba1337; shapes SAWTOOTH / SIN / SQUARE / PIANO; all envelopes gain 12349001, duration 42005678.
  - Required: exactly one frame_valid, 4 clk after csel rises; synth_out == the sent struct bit-exact; frame_err never asserts.
- Short frame (FRAME_BYTES-1 bytes, then csel high):
  - Required: frame_err pulse, no frame_valid, synth_out still holds the previous frame.
- Partial byte (full frame plus 3 extra bits) and overlong frame (FRAME_BYTES+1 bytes):
  - Required: frame_err pulse in each case; synth_out unchanged.
- Reset mid-frame: assert rst_n low after 10 bytes.
  - Required: synth_out = 0 and busy = 0 immediately, no pulses.
  - A following complete frame of all-8'h42 bytes commits correctly.
- Mode and bit order: single frame whose first byte is 8'h01, remaining bytes 0.
  - Required: synth_out MSB byte == 8'h01, confirming LSB-first bits and MSB-first bytes.
- SPI_ECHO_EN defined: send bytes 8'h12, 8'h34, ...
  - Required: MISO samples 8'hA5 during byte 0, 8'h12 during byte 1, 8'h34 during byte 2.
  - Without the macro, miso stays 0 throughout.
